// File: rtl/abc_sel.sv
// Min/max selector across N converter channels.
// Runs one conversion, scans the samples, then hands the result off over rfd/dav_.
module abc_sel #(
  parameter int W = 8,
  parameter int N = 3
) (
  input  logic           clock,
  input  logic           reset,
  output logic           soc,
  input  logic [N-1:0]   eoc,
  input  logic [N*W-1:0] x,
  input  logic [N-1:0]   ch_en,
  input  logic           mode,
  input  logic           rfd,
  output logic           dav_,
  output logic [W-1:0]   out,
  output logic [2:0]     idx
);

  typedef enum logic [2:0] {
    START,
    WAIT,
    SCAN,
    RDY,
    ACK
  } state_t;

  state_t         state;
  state_t         state_d;
  logic [N-1:0]   en_q;
  logic           mode_q;
  logic [W-1:0]   xs_q [N];
  logic [W-1:0]   acc;
  logic [2:0]     aidx;
  logic [2:0]     cnt;
  logic           found;
  logic [W-1:0]   smp;
  logic           smp_en;
  logic           better;
  logic           take;
  logic           last;

  always_comb begin
    smp    = '0;
    smp_en = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (cnt == 3'(i)) begin
        smp    = xs_q[i];
        smp_en = en_q[i];
      end
    end
    better = mode_q ? (smp > acc) : (smp < acc);
    take   = smp_en && (!found || better);
    last   = (cnt == 3'(N - 1));
  end

  always_comb begin
    state_d = state;
    unique case (state)
      START: if (|en_q && ((eoc & en_q) == '0)) state_d = WAIT;
      WAIT:  if ((eoc & en_q) == en_q) state_d = SCAN;
      SCAN:  if (last) state_d = RDY;
      RDY:   if (rfd) state_d = ACK;
      ACK:   if (!rfd) state_d = START;
      default: state_d = START;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= START;
    else       state <= state_d;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      soc    <= 1'b0;
      dav_   <= 1'b1;
      out    <= '0;
      idx    <= '0;
      found  <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      aidx   <= '0;
      en_q   <= '0;
      mode_q <= 1'b0;
      for (int i = 0; i < N; i++) xs_q[i] <= '0;
    end else begin
      soc <= (state_d == START);
      unique case (state)
        START: begin
          en_q   <= ch_en;
          mode_q <= mode;
        end
        WAIT: begin
          if (state_d == SCAN) begin
            for (int i = 0; i < N; i++) xs_q[i] <= x[i*W +: W];
            cnt   <= '0;
            found <= 1'b0;
          end
        end
        SCAN: begin
          if (take) begin
            acc   <= smp;
            aidx  <= cnt;
            found <= 1'b1;
          end
          cnt <= cnt + 3'd1;
        end
        RDY: begin
          if (rfd) begin
            out  <= acc;
            idx  <= aidx;
            dav_ <= 1'b0;
          end
        end
        ACK: begin
          if (!rfd) dav_ <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_abc_sel.sv
// Directed bench for abc_sel (N=3, W=8).
// Steps run on a 10-unit clock, sampling 1 unit after each rising edge.
module tb_abc_sel;

  logic        clock;
  logic        reset;
  logic        soc;
  logic [2:0]  eoc;
  logic [23:0] x;
  logic [2:0]  ch_en;
  logic        mode;
  logic        rfd;
  logic        dav_;
  logic [7:0]  out;
  logic [2:0]  idx;

  int total = 0;
  int bad   = 0;

  abc_sel #(.W(8), .N(3)) dut (
    .clock (clock),
    .reset (reset),
    .soc   (soc),
    .eoc   (eoc),
    .x     (x),
    .ch_en (ch_en),
    .mode  (mode),
    .rfd   (rfd),
    .dav_  (dav_),
    .out   (out),
    .idx   (idx)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    ch_en = 3'b111;
    mode  = 1'b0;
    x     = 24'h40_10_80;
    eoc   = 3'b000;
    rfd   = 1'b1;
    #2;
    chk("rst_soc", 32'(soc), 32'd0);
    chk("rst_dav", 32'(dav_), 32'd1);
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_idx", 32'(idx), 32'd0);
    tick();
    tick();
    reset = 1'b0;

    // minimum over all three channels
    tick();
    chk("soc_rise", 32'(soc), 32'd1);
    tick();
    chk("wait_soc", 32'(soc), 32'd0);
    eoc = 3'b111;
    tick();
    chk("e1_dav", 32'(dav_), 32'd1);
    tick();
    tick();
    tick();
    chk("e3_dav", 32'(dav_), 32'd1);
    tick();
    chk("min_dav", 32'(dav_), 32'd0);
    chk("min_out", 32'(out), 32'h10);
    chk("min_idx", 32'(idx), 32'd1);
    rfd = 1'b0;
    eoc = 3'b000;
    tick();
    chk("ack_dav", 32'(dav_), 32'd1);
    chk("ack_soc", 32'(soc), 32'd1);
    chk("ack_out", 32'(out), 32'h10);

    // maximum with a tie; inputs change after capture
    mode = 1'b1;
    x    = 24'h7F_7F_01;
    rfd  = 1'b1;
    tick();
    chk("max_wait", 32'(soc), 32'd0);
    eoc = 3'b111;
    tick();
    mode = 1'b0;
    x    = 24'h00_00_00;
    tick();
    tick();
    tick();
    tick();
    chk("max_dav", 32'(dav_), 32'd0);
    chk("max_out", 32'(out), 32'h7F);
    chk("max_idx", 32'(idx), 32'd1);
    rfd = 1'b0;
    eoc = 3'b000;
    tick();
    chk("max_ack", 32'(dav_), 32'd1);

    // single-channel mask plus backpressure
    ch_en = 3'b100;
    mode  = 1'b0;
    x     = 24'h90_00_00;
    tick();
    chk("msk_wait", 32'(soc), 32'd0);
    eoc = 3'b100;
    tick();
    tick();
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("bp_dav", 32'(dav_), 32'd1);
      chk("bp_out", 32'(out), 32'h7F);
      tick();
    end
    rfd = 1'b1;
    tick();
    chk("msk_dav", 32'(dav_), 32'd0);
    chk("msk_out", 32'(out), 32'h90);
    chk("msk_idx", 32'(idx), 32'd2);
    rfd = 1'b0;
    eoc = 3'b000;
    tick();
    chk("msk_ack", 32'(dav_), 32'd1);

    // asynchronous reset in the second scan cycle
    ch_en = 3'b111;
    x     = 24'h40_10_80;
    tick();
    eoc = 3'b111;
    tick();
    tick();
    #2;
    reset = 1'b1;
    #1;
    chk("ar_soc", 32'(soc), 32'd0);
    chk("ar_dav", 32'(dav_), 32'd1);
    chk("ar_out", 32'(out), 32'd0);
    chk("ar_idx", 32'(idx), 32'd0);

    // empty mask never leaves START
    ch_en = 3'b000;
    eoc   = 3'b000;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("nomask_soc", 32'(soc), 32'd1);
      chk("nomask_dav", 32'(dav_), 32'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/abc_sel.md
ABC_SEL -- requirements
Module: abc_sel

Interface
REQ-001 Parameter W, default 8: sample width in bits, range 2..16.
REQ-002 Parameter N, default 3: channel count, range 2..8.
REQ-003 clock  input  1  single system clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 soc  output  1  start of conversion to all N converters.
REQ-006 eoc  input  N  end of conversion, bit i from converter i.
REQ-007 x  input  N*W  samples; channel i is x[i*W+W-1 : i*W].
REQ-008 ch_en  input  N  channel enable mask; a disabled channel is ignored in every state.
REQ-009 mode  input  1  selection mode: 0 = minimum, 1 = maximum.
REQ-010 rfd  input  1  consumer ready-for-data.
REQ-011 dav_  output  1  data available, active low.
REQ-012 out  output  W  selected sample value.
REQ-013 idx  output  3  index of the channel that supplied out.

Function
REQ-014 The block SHALL implement five states: START, WAIT, SCAN, RDY and ACK.
REQ-015 START: soc SHALL be 1 and ch_en and mode SHALL be latched every cycle; the block SHALL go to WAIT when the latched mask is nonzero and all enabled eoc bits are 0. It SHALL stay in START when the mask is 0.
REQ-016 WAIT: soc SHALL be 0; the block SHALL go to SCAN when all enabled eoc bits are 1.
REQ-017 On the WAIT->SCAN edge, all N samples SHALL be captured into internal registers, the scan counter SHALL be cleared and the "found" flag SHALL be cleared.
REQ-018 SCAN: one channel SHALL be processed per clock, in index order 0..N-1, taking exactly N cycles. On each edge:
  - if channel CNT is enabled and (found=0, or its sample is strictly better than the accumulator), then ACC <= sample, AIDX <= CNT, found <= 1.
  - "Better" means strictly less when mode=0 and strictly greater when mode=1.
  - Comparison is unsigned W-bit.
REQ-019 Ties SHALL keep the lowest enabled index.
REQ-020 The block SHALL go to RDY after processing channel N-1.
REQ-021 RDY: the block SHALL wait for rfd=1. On that edge out <= ACC, idx <= AIDX, dav_ <= 0, and the state SHALL become ACK.
REQ-022 ACK: the block SHALL wait for rfd=0. On that edge dav_ <= 1 and the state SHALL become START.
REQ-023 out and idx SHALL change only on the RDY->ACK edge and SHALL hold their value otherwise.
REQ-024 Changes on mode, ch_en or x after they are latched or captured SHALL NOT affect the cycle in progress.
REQ-025 soc SHALL be registered and SHALL be 1 only in START; no new conversion SHALL begin before the ACK->START edge.
REQ-026 Latency: dav_ SHALL fall no earlier than N+1 rising edges after the edge on which WAIT sees all enabled eoc bits at 1, exactly N+1 when rfd is already 1.
REQ-027 When only one channel is enabled, out SHALL equal that channel's sample and idx SHALL equal its index.
REQ-028 eoc bits of disabled channels SHALL be don't-care in START and WAIT.

Reset
REQ-029 While reset=1, independent of clock, the block SHALL hold: state START, soc=0, dav_=1, out=0, idx=0, found=0, scan counter 0.
REQ-030 soc SHALL rise on the first rising edge after reset is released.
REQ-031 Reset asserted in any state, including mid-SCAN or with dav_=0, SHALL abort the cycle with no partial update of out or idx.

Verification (N=3, W=8)
REQ-032 Min: mode=0, ch_en=111, x={0x40,0x10,0x80} (ch2,ch1,ch0); eoc 111->000->111; rfd=1 -> out=0x10, idx=1, dav_ low 4 edges after eoc=111 is sampled; rfd->0 -> dav_=1, then soc=1.
REQ-033 Max with tie: mode=1, x={0x7F,0x7F,0x01} -> out=0x7F, idx=1.
REQ-034 Mask: mode=0, ch_en=100, x={0x90,0x00,0x00}, eoc[1:0] held at 0 throughout -> out=0x90, idx=2, no stall in WAIT.
REQ-035 Backpressure: rfd=0 at the end of SCAN -> state RDY, dav_=1, out unchanged; rfd=1 three cycles later -> dav_=0 on the next edge. With ch_en=000 -> soc stays 1 and the block never leaves START.
REQ-036 Reset mid-SCAN (second scan cycle) -> soc=0, dav_=1, out=0, idx=0 immediately, with no clock required.
